// File: rtl/max7219_pkg.sv
// max7219_pkg: shift modes and FSM state encodings shared by the shift matrix.
package max7219_pkg;
  typedef enum logic [1:0] {SHL_FILL = 2'd0, SHR_FILL = 2'd1, ROTL = 2'd2, ROTR = 2'd3} mode_t;
  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;
endpackage

// File: rtl/shift_row.sv
// shift_row: one matrix row with parallel load and a single-step shift/rotate.
module shift_row
  import max7219_pkg::*;
#(
  parameter int COLS = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  input  mode_t           mode,
  input  logic            fill,
  input  logic            en,
  input  logic            load,
  input  logic [COLS-1:0] load_val,
  output logic [COLS-1:0] row,
  output logic            exit_bit
);
  logic            in_bit;
  logic [COLS-1:0] nxt;
  // mode[0] picks direction, mode[1] makes the exiting bit re-enter (rotate)
  always_comb begin
    exit_bit = mode[0] ? row[0] : row[COLS-1];
    in_bit   = mode[1] ? exit_bit : fill;
    nxt      = mode[0] ? {in_bit, row[COLS-1:1]} : {row[COLS-2:0], in_bit};
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) row <= '0;
    else if (load) row <= load_val;
    else if (en) row <= nxt;
endmodule

// File: rtl/shift_matrix.sv
// shift_matrix: ROWSxCOLS pixel image shifted/rotated a commanded number of ticks.
module shift_matrix
  import max7219_pkg::*;
#(
  parameter int ROWS  = 8,
  parameter int COLS  = 8,
  parameter int CNT_W = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 tick,
  input  logic                 start,
  input  logic                 stop,
  input  logic [1:0]           mode,
  input  logic [CNT_W-1:0]     steps,
  input  logic [ROWS-1:0]      d,
  input  logic                 load,
  input  logic [ROWS*COLS-1:0] load_data,
  output logic                 busy,
  output logic                 done,
  output logic [ROWS-1:0]      ex,
  output logic [ROWS*COLS-1:0] out
);
  state_t          state, state_n;
  mode_t           mode_q;
  logic [CNT_W-1:0] rem;
  logic            step, load_en, go;
  logic [ROWS-1:0] exits;
  assign load_en = state == IDLE && load;
  assign go      = state == IDLE && start && !load;
  assign step    = state == RUN && tick && !stop;
  always_comb
    state_n = state == IDLE ? (go ? (steps == '0 ? DONE : RUN) : IDLE) :
              state == RUN  ? (stop ? IDLE : (tick && rem == CNT_W'(1)) ? DONE : RUN) :
              IDLE;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state  <= IDLE;
      mode_q <= SHL_FILL;
      rem    <= '0;
      ex     <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
    end else begin
      state <= state_n;
      busy  <= state_n == RUN;
      done  <= state_n == DONE;
      if (go) begin
        mode_q <= mode_t'(mode);
        rem    <= steps;
      end else if (step) rem <= rem - 1'b1;
      if (step) ex <= exits;
    end
  for (genvar r = 0; r < ROWS; r++) begin : g_row
    shift_row #(.COLS(COLS)) u_row (
      .clk      (clk),
      .rst_n    (rst_n),
      .mode     (mode_q),
      .fill     (d[r]),
      .en       (step),
      .load     (load_en),
      .load_val (load_data[r*COLS +: COLS]),
      .row      (out[r*COLS +: COLS]),
      .exit_bit (exits[r])
    );
  end
endmodule

// File: doc/shift_matrix.md
SHIFT_MATRIX -- requirements
Module: shift_matrix

Interface
REQ-001 SHALL have parameter ROWS, default 8: number of matrix rows.
REQ-002 SHALL have parameter COLS, default 8: pixels per row.
REQ-003 SHALL have parameter CNT_W, default 8: width of the step counter.
REQ-004 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst_n  input  1  reset; asynchronous and active-low.
REQ-006 SHALL have port tick  input  1  step strobe; one shift per tick while running.
REQ-007 SHALL have port start  input  1  command request, sampled in IDLE.
REQ-008 SHALL have port stop  input  1  abort of a running command.
REQ-009 SHALL have port mode  input  2  0 shl-fill, 1 shr-fill, 2 rotl, 3 rotr.
REQ-010 SHALL have port steps  input  CNT_W  number of shifts for the command.
REQ-011 SHALL have port d  input  ROWS  fill column; d[r] feeds row r.
REQ-012 SHALL have port load  input  1  parallel-load strobe.
REQ-013 SHALL have port load_data  input  ROWS*COLS  image for parallel load.
REQ-014 SHALL have port busy  output  1  high while a command runs.
REQ-015 SHALL have port done  output  1  single-cycle completion pulse.
REQ-016 SHALL have port ex  output  ROWS  registered column shifted out by the last step.
REQ-017 SHALL have port out  output  ROWS*COLS  pixel image; row r = out[r*COLS +: COLS], bit 0 = column 0.

Function
REQ-018 SHALL implement FSM states IDLE, RUN, DONE.
REQ-019 SHALL, in IDLE with start=1 and steps>0, latch mode and steps into the remaining counter and enter RUN.
REQ-020 SHALL, in IDLE with start=1 and steps=0, enter DONE without modifying out or ex.
REQ-021 SHALL, in RUN with tick=1, perform one shift on every row, load ex, and decrement the remaining counter.
REQ-022 SHALL enter DONE on the tick that brings the remaining counter from 1 to 0.
REQ-023 SHALL remain in DONE for exactly one cycle, then return to IDLE.
REQ-024 SHALL, in mode 0, shift each row toward the MSB with d[r] entering bit 0; ex[r] takes the old bit COLS-1.
REQ-025 SHALL, in mode 1, shift each row toward the LSB with d[r] entering bit COLS-1; ex[r] takes the old bit 0.
REQ-026 SHALL, in modes 2 and 3, rotate left or right respectively, ignore d, and set ex[r] to the bit that wrapped.
REQ-027 SHALL sample d only on the tick cycle of each step.
REQ-028 SHALL, in RUN with stop=1, return to IDLE with no done pulse; a tick in the same cycle is not applied.
REQ-029 SHALL, in IDLE with load=1, write load_data into out in one cycle and leave ex unchanged.
REQ-030 SHALL give load priority over start when both are asserted in IDLE; that start is dropped.
REQ-031 SHALL ignore start and load outside IDLE, and ignore stop outside RUN.
REQ-032 SHALL drive busy=1 exactly while in RUN and done=1 exactly while in DONE; both registered.
REQ-033 SHALL hold out and ex unchanged in every cycle in which no shift or load occurs.

Reset
REQ-034 SHALL, while rst_n=0, immediately force state IDLE, out=0, ex=0, busy=0, done=0, and the remaining counter to 0.
REQ-035 SHALL, on reset asserted during RUN, abandon the command with no done pulse.

Structure
REQ-036 SHALL take the mode encodings and FSM state encodings from the shared package max7219_pkg.
REQ-037 SHALL instantiate sub-module shift_row (COLS-wide, one per row; inputs: mode, fill bit, step enable; outputs: row value and exit bit) ROWS times.

Verification
REQ-038 SHALL check: reset -> out=0, ex=0, busy=0, done=0.
REQ-039 SHALL check: load 64'h81, start mode 0 steps 1, d=8'h01, one tick -> out=64'h03, ex=8'h01, done pulse one cycle later.
REQ-040 SHALL check: out=64'h01, mode 3 steps 3, ticks spaced 4 cycles apart -> out=64'h20, ex=8'h00; busy high until the third tick; single done pulse.
REQ-041 SHALL check: start with steps=0 -> done in the next cycle, busy never high, out unchanged.
REQ-042 SHALL check: out=0, mode 1 steps 8, d=8'hFF on every tick -> out=all ones; start and load issued mid-run are ignored.
REQ-043 SHALL check: mode 0 steps 5, stop after 2 ticks -> IDLE, no done, two shifts applied; repeat with rst_n low after 2 ticks -> out=0 immediately.
